// File: rtl/phase_readout.sv
// Majority-vote phase readout of an RO spin array against a reference tap.
// Ports: start/window in, async ref_in/osc_in, busy/valid/spins/counts out.
module phase_readout #(
  parameter int NUM_SPINS    = 4,
  parameter int COUNTER_BITS = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [COUNTER_BITS-1:0]           window,
  input  logic                              ref_in,
  input  logic [NUM_SPINS-1:0]              osc_in,
  output logic                              busy,
  output logic                              valid,
  output logic [NUM_SPINS-1:0]              spins,
  output logic [NUM_SPINS*COUNTER_BITS-1:0] counts
);

  localparam int CB = COUNTER_BITS;
  localparam int N  = NUM_SPINS;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE
  } state_t;

  state_t          state_q, state_d;
  logic            settle_q, settle_d;
  logic [CB-1:0]   samp_q, samp_d;
  logic [CB-1:0]   win_q, win_d;
  logic [N*CB-1:0] cnt_q, cnt_d;
  logic [N-1:0]    spins_q, spins_d;
  logic            valid_q, valid_d;

  logic            ref_m_q, ref_s_q;
  logic [N-1:0]    osc_m_q, osc_s_q;

  // Two-flop synchronizers for the free-running oscillator taps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_m_q <= 1'b0;
      ref_s_q <= 1'b0;
      osc_m_q <= '0;
      osc_s_q <= '0;
    end else begin
      ref_m_q <= ref_in;
      ref_s_q <= ref_m_q;
      osc_m_q <= osc_in;
      osc_s_q <= osc_m_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    spins_d  = spins_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start && (window != '0)) begin
          win_d    = window;
          cnt_d    = '0;
          valid_d  = 1'b0;
          settle_d = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Two cycles lets the synchronizer pipes fill with live data.
        settle_d = 1'b1;
        if (settle_q) begin
          samp_d  = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        for (int i = 0; i < N; i++) begin
          cnt_d[i*CB +: CB] = cnt_q[i*CB +: CB]
                            + {{(CB-1){1'b0}}, ref_s_q ^ osc_s_q[i]};
        end
        samp_d = samp_q + 1'b1;
        if (samp_d == win_q) begin
          // Strict majority; a tie reads as in-phase.
          for (int i = 0; i < N; i++) begin
            spins_d[i] = {cnt_d[i*CB +: CB], 1'b0} > {1'b0, win_q};
          end
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      settle_q <= 1'b0;
      samp_q   <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      spins_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      spins_q  <= spins_d;
      valid_q  <= valid_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = valid_q;
  assign spins  = spins_q;
  assign counts = cnt_q;

endmodule

// File: tb/tb_phase_readout.sv
// Scoreboard bench for phase_readout.
// Random windows/inputs checked against a mismatch-count majority model.
module tb_phase_readout;

  localparam int N  = 4;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] window = '0;
  logic          ref_in = 1'b0;
  logic [N-1:0]  osc_in = '0;
  logic          busy;
  logic          valid;
  logic [N-1:0]  spins;
  logic [N*CB-1:0] counts;

  phase_readout #(.NUM_SPINS(N), .COUNTER_BITS(CB)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .window(window),
    .ref_in(ref_in),
    .osc_in(osc_in),
    .busy  (busy),
    .valid (valid),
    .spins (spins),
    .counts(counts)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [N-1:0]    sp;
    logic [N*CB-1:0] ct;
  } exp_t;

  exp_t q[$];
  exp_t last;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every newly valid result against the scoreboard.
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (valid && !vprev) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("spins", 64'(spins), 64'(e.sp));
        check("counts", 64'(counts), 64'(e.ct));
      end
    end
    vprev = valid;
  end

  // mode 0: random inputs, 1: static sr/so, 2: osc0 matches ref for
  // samples 1-2 and differs afterwards. inject: sample number at which
  // a start with window=5 is pulsed. abort_at: sample number at which
  // reset is asserted.
  task automatic run(input int w, input int mode, input logic sr,
                     input logic [N-1:0] so, input int inject,
                     input int abort_at);
    int mm[N];
    int busy_n;
    int t;
    logic r;
    logic [N-1:0] o;
    exp_t e;
    busy_n = 0;
    for (int i = 0; i < N; i++) mm[i] = 0;
    @(negedge clk);
    start  = 1'b1;
    window = CB'(w);
    @(posedge clk);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      start  = (k == inject);
      window = (k == inject) ? CB'(5) : '0;
      if (k == abort_at) begin
        rstn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_counts", 64'(counts), 64'd0);
        check("abort_spins", 64'(spins), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (mode == 1) begin
        r = sr;
        o = so;
      end else begin
        r = 1'($urandom);
        o = N'($urandom);
        if (mode == 2) o[0] = (k <= 2) ? r : ~r;
      end
      ref_in = r;
      osc_in = o;
      for (int i = 0; i < N; i++) mm[i] += int'(r ^ o[i]);
      @(posedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.ct[i*CB +: CB] = CB'(mm[i]);
      e.sp[i] = (2 * mm[i] > w);
    end
    q.push_back(e);
    last = e;
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
      t++;
      if (t > 10) begin
        check("busy_timeout", 64'd1, 64'd0);
        break;
      end
    end
    check("busy_cycles", 64'(busy_n), 64'(w + 2));
    check("valid_after", 64'(valid), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_spins", 64'(spins), 64'd0);
    check("rst_counts", 64'(counts), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    run(10, 1, 1'b1, 4'b1111, 0, 0);
    run(10, 1, 1'b1, 4'b0101, 0, 0);
    run(4, 2, 1'b0, 4'b0000, 0, 0);
    run(20, 0, 1'b0, 4'b0000, 5, 0);

    // start with a zero window must be ignored.
    @(negedge clk);
    start  = 1'b1;
    window = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("w0_busy", 64'(busy), 64'd0);
    check("w0_valid", 64'(valid), 64'd1);
    check("w0_spins", 64'(spins), 64'(last.sp));
    check("w0_counts", 64'(counts), 64'(last.ct));

    run(50, 0, 1'b0, 4'b0000, 0, 7);
    run(3, 0, 1'b0, 4'b0000, 0, 0);
    run(1, 0, 1'b0, 4'b0000, 0, 0);
    run(255, 0, 1'b0, 4'b0000, 0, 0);
    for (int n = 0; n < 8; n++) begin
      run($urandom_range(1, 40), 0, 1'b0, 4'b0000, 0, 0);
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
